// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight writers in a shift-register scoreboard and
// produces load-use stalls, registered EX forwarding selects and redirect flush masks.
// Optional macro HAZARD_PERF_EN adds the stall_cnt/flush_cnt event counters.
`timescale 1ns/1ps
module hazard_scoreboard #(
  parameter int REG_AW       = 5,
  parameter int FWD_STAGES   = 2,
  parameter int LOAD_LAT     = 1,
  parameter int REDIRECT_POS = 2,
  parameter int SEL_W        = $clog2(FWD_STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_AW-1:0]       id_rs1,
  input  logic [REG_AW-1:0]       id_rs2,
  input  logic                    id_use_rs1,
  input  logic                    id_use_rs2,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic                    id_regwrite,
  input  logic                    id_is_load,
  input  logic                    redirect,
  output logic                    stall,
  output logic                    issue,
  output logic [REDIRECT_POS:0]   flush_mask,
  output logic [SEL_W-1:0]        fwd_a,
  output logic [SEL_W-1:0]        fwd_b
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             flush_cnt
`endif
);

  localparam int NPOS = FWD_STAGES + 1;

  logic [NPOS:1]             vld_q, vld_d;
  logic [NPOS:1]             ld_q, ld_d;
  logic [NPOS:1][REG_AW-1:0] rd_q, rd_d;
  logic [SEL_W-1:0]          fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0]          fwd_b_q, fwd_b_d;

  int               pos_a_s, pos_b_s;
  logic             ld_a_s, ld_b_s;
  logic             lu_s;
  logic [SEL_W-1:0] sel_a_s, sel_b_s;

  // Youngest (smallest position) valid, non-x0 writer of rs; pos = 0 when nothing matches.
  function automatic void youngest_match(
    input  logic [NPOS:1]             vld,
    input  logic [NPOS:1]             ld,
    input  logic [NPOS:1][REG_AW-1:0] rd,
    input  logic [REG_AW-1:0]         rs,
    input  logic                      use_rs,
    output int                        pos,
    output logic                      is_ld
  );
    pos   = 0;
    is_ld = 1'b0;
    for (int p = NPOS; p >= 1; p--) begin
      if (use_rs && vld[p] && (rd[p] != '0) && (rd[p] == rs)) begin
        pos   = p;
        is_ld = ld[p];
      end else begin
        pos   = pos;
        is_ld = is_ld;
      end
    end
  endfunction

  // Operand lookup, load-use stall, issue and flush decisions.
  always_comb begin
    youngest_match(vld_q, ld_q, rd_q, id_rs1, id_use_rs1, pos_a_s, ld_a_s);
    youngest_match(vld_q, ld_q, rd_q, id_rs2, id_use_rs2, pos_b_s, ld_b_s);
    lu_s = ((pos_a_s != 0) && (pos_a_s <= LOAD_LAT) && ld_a_s) ||
           ((pos_b_s != 0) && (pos_b_s <= LOAD_LAT) && ld_b_s);
    if (rst && id_valid && !redirect) begin
      stall = lu_s;
    end else begin
      stall = 1'b0;
    end
    issue = rst & id_valid & ~stall & ~redirect;
    if (rst && redirect) begin
      flush_mask = '1;
    end else begin
      flush_mask = '0;
    end
    // Entries older than the forwarding reach come from the register file.
    if ((pos_a_s >= 1) && (pos_a_s <= FWD_STAGES)) begin
      sel_a_s = SEL_W'(pos_a_s);
    end else begin
      sel_a_s = '0;
    end
    if ((pos_b_s >= 1) && (pos_b_s <= FWD_STAGES)) begin
      sel_b_s = SEL_W'(pos_b_s);
    end else begin
      sel_b_s = '0;
    end
  end

  // Next-state for the forwarding selects and the scoreboard shift.
  always_comb begin
    if (issue) begin
      fwd_a_d = sel_a_s;
      fwd_b_d = sel_b_s;
    end else if (stall) begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
    end else begin
      fwd_a_d = '0;
      fwd_b_d = '0;
    end
    vld_d = vld_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    for (int p = NPOS; p >= 2; p--) begin
      vld_d[p] = vld_q[p-1] & !(redirect && ((p - 1) < REDIRECT_POS));
      ld_d[p]  = ld_q[p-1];
      rd_d[p]  = rd_q[p-1];
    end
    vld_d[1] = issue & id_regwrite;
    ld_d[1]  = id_is_load;
    rd_d[1]  = id_rd;
  end

  // Scoreboard and forwarding-select registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      vld_q   <= vld_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event counters; both wrap naturally at 2^32.
  always_comb begin
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (redirect) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard; forwarding expectations flow through a queue
// one cycle behind the stimulus, matching the registered fwd_a/fwd_b outputs.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load, redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, issue, stall2, issue2;
  logic [2:0] flush_mask, flush_mask2;
  logic [1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .redirect(redirect),
    .stall(stall), .issue(issue), .flush_mask(flush_mask), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  hazard_scoreboard #(.FWD_STAGES(3), .LOAD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .redirect(redirect),
    .stall(stall2), .issue(issue2), .flush_mask(flush_mask2), .fwd_a(fwd_a2), .fwd_b(fwd_b2)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
`endif
  );

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       rdr;
    logic       e_stall;
    logic       e_issue;
    logic [2:0] e_flush;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
  } vec_t;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
  } fwd_exp_t;

  fwd_exp_t fwd_q[$];
  vec_t     tbl[22];
  int       n_pass = 0;
  int       n_total = 0;
  logic       s2_stall, s2_issue;
  logic [2:0] s2_flush;
  logic [1:0] s2_fa, s2_fb;

  function automatic vec_t mk(input int vld, input int rs1, input int rs2, input int u1,
                              input int u2, input int rd, input int wr, input int ld,
                              input int rdr, input int st, input int is, input int fl,
                              input int fa, input int fb);
    vec_t v;
    v.vld = 1'(vld);  v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
    v.rd = 5'(rd);    v.wr = 1'(wr);   v.ld = 1'(ld);   v.rdr = 1'(rdr);
    v.e_stall = 1'(st); v.e_issue = 1'(is); v.e_flush = 3'(fl);
    v.e_fa = 2'(fa);  v.e_fb = 2'(fb);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    id_rd = v.rd; id_regwrite = v.wr; id_is_load = v.ld; redirect = v.rdr;
  endtask

  task automatic push_zero();
    fwd_exp_t z;
    z.fa = 2'd0;
    z.fb = 2'd0;
    fwd_q.push_back(z);
  endtask

  // One pipeline cycle: drive at posedge+1, sample at negedge, queue next-cycle fwd expectation.
  task automatic run_vec(input vec_t v, input int idx);
    fwd_exp_t e;
    fwd_exp_t n;
    drive(v);
    @(negedge clk);
    chk($sformatf("v%0d stall", idx), int'(stall), int'(v.e_stall));
    chk($sformatf("v%0d issue", idx), int'(issue), int'(v.e_issue));
    chk($sformatf("v%0d flush_mask", idx), int'(flush_mask), int'(v.e_flush));
    if (fwd_q.size() == 0) begin
      n_total++;
      $display("FAIL v%0d fwd: expectation queue empty", idx);
    end else begin
      e = fwd_q.pop_front();
      chk($sformatf("v%0d fwd_a", idx), int'(fwd_a), int'(e.fa));
      chk($sformatf("v%0d fwd_b", idx), int'(fwd_b), int'(e.fb));
    end
    s2_stall = stall2; s2_issue = issue2; s2_flush = flush_mask2; s2_fa = fwd_a2; s2_fb = fwd_b2;
    n.fa = v.e_fa;
    n.fb = v.e_fb;
    fwd_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    fwd_q.delete();
    push_zero();
  endtask

  initial begin
    //         vld rs1 rs2 u1 u2 rd wr ld rdr | stall issue flush fa fb(next cycle)
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 5, 0, 1, 0, 8, 1, 0, 0,  0, 1, 0, 1, 0);
    tbl[3]  = mk(1, 5, 0, 1, 0, 9, 1, 0, 0,  0, 1, 0, 2, 0);
    tbl[4]  = mk(1, 5, 5, 1, 1, 0, 1, 1, 0,  0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 1, 1,10, 1, 0, 0,  0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 1, 0, 6, 1, 1, 0,  0, 1, 0, 0, 0);
    tbl[7]  = mk(1, 2, 6, 1, 1,11, 1, 0, 0,  1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 2, 6, 1, 1,11, 1, 0, 0,  0, 1, 0, 0, 2);
    tbl[9]  = mk(1,11, 0, 1, 0,12, 1, 1, 0,  0, 1, 0, 1, 0);
    tbl[10] = mk(1,12,11, 1, 1,13, 1, 0, 0,  1, 0, 0, 1, 0);
    tbl[11] = mk(1,12,11, 1, 1,13, 1, 0, 0,  0, 1, 0, 2, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0,  0, 1, 0, 0, 0);
    tbl[13] = mk(1, 7, 0, 0, 0, 7, 1, 0, 0,  0, 1, 0, 0, 0);
    tbl[14] = mk(1, 7, 7, 1, 1,14, 1, 0, 0,  0, 1, 0, 1, 1);
    tbl[15] = mk(1, 0, 0, 0, 0, 6, 1, 1, 0,  0, 1, 0, 0, 0);
    tbl[16] = mk(1,14, 6, 1, 1,11, 1, 0, 1,  0, 0, 7, 0, 0);
    tbl[17] = mk(1, 6,14, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 7, 0, 0);
    tbl[19] = mk(1, 0, 0, 0, 0, 3, 1, 1, 0,  0, 1, 0, 0, 0);
    tbl[20] = mk(0, 3, 3, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    // Outputs held at zero while in reset, even with a redirect and valid ID instruction.
    rst = 1'b0;
    drive(mk(1, 6, 6, 1, 1, 6, 1, 1, 1,  0, 0, 0, 0, 0));
    #3;
    chk("rst stall", int'(stall), 0);
    chk("rst issue", int'(issue), 0);
    chk("rst flush_mask", int'(flush_mask), 0);
    chk("rst fwd_a", int'(fwd_a), 0);
    chk("rst fwd_b", int'(fwd_b), 0);
    drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    @(posedge clk);
    #1 rst = 1'b1;
    push_zero();

    // Asynchronous reset in the middle of a load-use stall.
    run_vec(mk(1, 0, 0, 0, 0, 6, 1, 1, 0,  0, 1, 0, 0, 0), 100);
    drive(mk(1, 0, 6, 0, 1, 11, 1, 0, 0,  0, 0, 0, 0, 0));
    @(negedge clk);
    chk("mid stall before rst", int'(stall), 1);
    chk("mid issue before rst", int'(issue), 0);
    #1 rst = 1'b0;
    redirect = 1'b1;
    #1;
    chk("mid rst stall", int'(stall), 0);
    chk("mid rst issue", int'(issue), 0);
    chk("mid rst flush_mask", int'(flush_mask), 0);
    chk("mid rst fwd_b", int'(fwd_b), 0);
    #1 redirect = 1'b0;
    #1 rst = 1'b1;
    fwd_q.delete();
    push_zero();
    @(posedge clk);
    #1;
    run_vec(mk(1, 0, 6, 0, 1, 11, 1, 0, 0,  0, 1, 0, 0, 0), 101);

`ifdef HAZARD_PERF_EN
    do_reset();
    chk("stall_cnt after reset", int'(stall_cnt), 0);
    chk("flush_cnt after reset", int'(flush_cnt), 0);
    for (int k = 0; k < 5; k++) begin
      run_vec(mk(1, 0, 0, 0, 0, 6, 1, 1, 0,  0, 1, 0, 0, 0), 200 + 3 * k);
      run_vec(mk(1, 0, 6, 0, 1,11, 1, 0, 0,  1, 0, 0, 0, 0), 201 + 3 * k);
      run_vec(mk(1, 0, 6, 0, 1,11, 1, 0, 0,  0, 1, 0, 0, 2), 202 + 3 * k);
    end
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 7, 0, 0), 230);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 7, 0, 0), 231);
    chk("stall_cnt", int'(stall_cnt), 5);
    chk("flush_cnt", int'(flush_cnt), 2);
`endif

    do_reset();
    for (int i = 0; i < 22; i++) run_vec(tbl[i], i);

    // LOAD_LAT=2 / FWD_STAGES=3 instance: two stall cycles, then forward from position 3.
    do_reset();
    run_vec(mk(1, 0, 0, 0, 0, 6, 1, 1, 0,  0, 1, 0, 0, 0), 300);
    run_vec(mk(1, 0, 6, 0, 1,11, 1, 0, 0,  1, 0, 0, 0, 0), 301);
    chk("ll2 stall cycle1", int'(s2_stall), 1);
    run_vec(mk(1, 0, 6, 0, 1,11, 1, 0, 0,  0, 1, 0, 0, 2), 302);
    chk("ll2 stall cycle2", int'(s2_stall), 1);
    chk("ll2 issue cycle2", int'(s2_issue), 0);
    run_vec(mk(1, 0, 6, 0, 1,11, 1, 0, 0,  0, 1, 0, 0, 0), 303);
    chk("ll2 stall released", int'(s2_stall), 0);
    chk("ll2 issue released", int'(s2_issue), 1);
    chk("ll2 flush_mask", int'(s2_flush), 0);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0), 304);
    chk("ll2 fwd_b", int'(s2_fb), 3);
    chk("ll2 fwd_a", int'(s2_fa), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the RV32 pipeline. It replaces the fixed two-source forwarding unit and the ad-hoc branch flush muxes.
- Sits beside the ID stage and tracks in-flight register writers in a shift-register scoreboard.
- Produces load-use stalls, registered forwarding selects for EX, and flush masks on control redirects.
- Depth, forwarding reach, load latency and redirect stage are all configurable.

Parameters:
- REG_AW, 5: register index width; x0 is never a hazard.
- FWD_STAGES, 2: number of post-EX positions that can forward; selects 1..FWD_STAGES (1 = EX/MEM, 2 = MEM/WB, ...).
- LOAD_LAT, 1: load data not forwardable until scoreboard position > LOAD_LAT.
- REDIRECT_POS, 2: position in which branches/jumps resolve (1 = EX, 2 = MEM).
- SEL_W, $clog2(FWD_STAGES+1): forwarding select width.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous active-low reset
- id_valid  input  1  valid instruction in ID
- id_rs1  input  REG_AW  source 1 index
- id_rs2  input  REG_AW  source 2 index
- id_use_rs1  input  1  instruction reads rs1
- id_use_rs2  input  1  instruction reads rs2
- id_rd  input  REG_AW  destination index
- id_regwrite  input  1  instruction writes rd
- id_is_load  input  1  instruction is a load
- redirect  input  1  taken branch/jump resolved at REDIRECT_POS this cycle
- stall  output  1  hold PC and IF/ID; bubble into ID/EX (combinational)
- issue  output  1  ID instruction enters EX this cycle (combinational)
- flush_mask  output  REDIRECT_POS+1  bit0 = IF/ID, bit i = scoreboard position i; squash (combinational)
- fwd_a  output  SEL_W  EX operand A source: 0 = regfile, k = position k (registered)
- fwd_b  output  SEL_W  EX operand B source, same encoding (registered)

Behaviour:
- Scoreboard entries are positions 1..FWD_STAGES+1, each holding {valid, rd, is_load}. Position 1 = EX.
- Every clock edge, entries shift p -> p+1 and the last position retires. Position 1 loads the ID instruction if issue=1, otherwise a bubble (valid=0).
- Match at position p: entry valid, rd != 0, rd == id_rsX, and id_use_rsX=1.
- Youngest match (smallest p) wins per operand.
- Load-use: if a matching entry has is_load=1 and p <= LOAD_LAT, then stall=1 (when id_valid=1 and redirect=0).
- Forward select for the EX cycle: youngest matching p gives sel = p, provided p <= FWD_STAGES. No match, or p > FWD_STAGES, gives sel = 0; the register file must write before it reads.
- fwd_a/fwd_b are registered on the edge where issue=1. They hold their value while stall=1 and are 0 after a bubble. Latency: 1 cycle, aligned with the instruction's EX cycle.
- issue = id_valid & ~stall & ~redirect.
- redirect=1:
  - flush_mask = all ones for that cycle; stall=0; issue=0.
  - On the edge, entries at positions < REDIRECT_POS are invalidated before the shift. The redirecting instruction and older entries are kept.
- redirect and load-use in the same cycle: redirect wins.
- Otherwise flush_mask = 0.
- rd = 0 writers enter the table but never match.
- Multiple hazards on rs1 and rs2: the stall is the OR of both. Forward selects are independent per operand.
- Reset (async, rst=0): all entries invalid; fwd_a = fwd_b = 0. stall, issue and flush_mask are 0 while in reset. Reset mid-stall is a clean restart with no residual stall.
- Back-to-back stalls are allowed. A stall ends when the load reaches position LOAD_LAT+1.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with redirect=1.
  - Both counters wrap at 2^32 and are cleared by reset.
- Undefined: the counters and their ports are absent; behaviour is otherwise identical.

Test Plan:
1. Defaults. ALU x5 <- ..., next instruction reads rs1=x5 -> stall=0, fwd_a=1 in its EX cycle. An instruction two behind reading x5 -> fwd_a=2.
2. Load x6, next instruction reads rs2=x6 -> stall=1 for exactly 1 cycle, issue=0 that cycle, then fwd_b=2. With LOAD_LAT=2 -> 2 stall cycles, then fwd_b=3 if FWD_STAGES=3, otherwise 0.
3. Writer rd=x0, consumer reads x0 -> no stall, fwd_a = fwd_b = 0.
4. Two writers to x7 at positions 1 and 2, consumer reads x7 on both operands -> fwd_a = fwd_b = 1 (youngest wins).
5. redirect=1 while a load-use stall is pending -> stall=0, flush_mask=3'b111, position 1 entry invalidated. The following consumer of that squashed rd sees fwd=0.
6. rst pulled low mid-stall for 3 ns, asynchronously -> outputs go to 0 immediately, scoreboard empty after release. With HAZARD_PERF_EN, 5 stalls + 2 redirects -> stall_cnt=5, flush_cnt=2.
